cnt_capture: RTL and testbench
==============================

Name: cnt_capture

Overview:
Input-capture timer, the measuring counterpart of the cnt/clkdiv period generators. It measures the period and high time of an external periodic signal in clk cycles. Each complete period produces a one-cycle valid strobe and sets a sticky interrupt. It is used to check clkdiv outputs and to measure external clocks and PWM inputs.

Parameters:
width, 32, bit width of the counter and of the captured period/high values (min 4)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous active-high reset
en  input  1  capture enable; deassertion aborts the current measurement
sig  input  1  measured signal, asynchronous to clk
ack  input  1  interrupt acknowledge; clears it
period  output  width  last captured period in clk cycles (rise to rise)
high  output  width  last captured high time in clk cycles (rise to fall)
valid  output  1  one-cycle strobe when period/high/ovf update
ovf  output  1  last captured period saturated
it  output  1  sticky interrupt; set on capture

Behaviour:
- Synchronizer: sig passes through 2 flops to give s; s_d is s delayed 1 cycle.
- Edge detect: rise = s & ~s_d; fall = ~s & s_d.
- Reset (rst=1 at posedge): state IDLE; sync flops, s_d and pcnt cleared; sat and high_lat cleared; period, high, valid, ovf and it all 0.
- States:
  - IDLE: go to WAIT_LOW when en=1.
  - WAIT_LOW: go to WAIT_RISE when s=0. This discards a fake rise caused by sig already being high at reset release or at enable.
  - WAIT_RISE: on rise, set pcnt<=1, sat<=0, high_lat<=max, go to RUN. No capture happens on this first rise.
  - RUN: each cycle without rise, pcnt<=pcnt+1, saturating at 2^width-1. Reaching saturation sets sat<=1 and pcnt holds.
  - RUN on fall: high_lat<=pcnt. If pcnt is saturated, high_lat is max.
  - RUN on rise: period<=pcnt, high<=high_lat, ovf<=sat, valid<=1 for one cycle, it<=1. Then pcnt<=1, sat<=0, high_lat<=max, stay in RUN.
- en=0 in any state: go to IDLE next cycle, clear pcnt, sat and high_lat. period, high, ovf and it hold. A measurement in progress is discarded with no valid strobe.
- Interrupt:
  - it is set on capture and cleared when ack=1.
  - If capture and ack occur in the same cycle, set wins and it=1.
  - ack while it=0 has no effect.
- Values: for a signal with period P and high time H cycles, period=P and high=H exactly, with no off-by-one.
- Latency: valid asserts in the cycle after the 3rd posedge following the sig rising transition (2 synchronizer stages plus 1 capture register).
- Input constraint: sig must stay at each level for at least 2 clk cycles to be measured correctly. Shorter pulses may be missed; behaviour then stays defined but the values are unspecified.
- Saturation: if pcnt saturates before the next rise, that capture reports period=2^width-1 and ovf=1. The following capture reports normally with ovf=0. A stuck sig produces no capture at all.
- rst has priority over en and ack.

Test Plan:
- Basic capture:
  - Stimulus: rst, then en=1; sig with period 10, high 4, starting low; width=8.
  - Required: first rise produces no valid. Every later rise gives valid with period=10, high=4, ovf=0, and it=1 after the first capture.
- Sig high at reset release:
  - Stimulus: sig held high through rst, then the same 10/4 waveform.
  - Required: no capture on the synchronizer-induced rise. The first valid reports period=10, high=4.
- Saturation:
  - Stimulus: width=4; sig high 3 cycles, then low 30 cycles, then a 10/4 waveform.
  - Required: the capture after the long period gives period=15, high=3, ovf=1. The next capture gives period=10, high=4, ovf=0.
- Interrupt handshake:
  - Stimulus: ack pulsed 2 cycles after valid, then ack held high in the same cycle as the next valid.
  - Required: it=0 after the first ack. it=1 after the simultaneous capture+ack.
- Enable abort:
  - Stimulus: drop en for 1 cycle mid-period, then restore it.
  - Required: no valid for the aborted period. period/high keep their old values. The next valid comes only after WAIT_LOW and WAIT_RISE plus one full period.
- Mid-operation reset:
  - Stimulus: rst asserted 1 cycle during RUN with it=1.
  - Required: next cycle all outputs are 0 and state is IDLE. A capture only occurs after the full re-arm sequence.

Source files
------------

// File: rtl/cnt_capture_if.sv
// Capture-timer bus: control/measured-signal inputs and captured-result outputs.
interface cnt_capture_if #(
  parameter int width = 32
);
  logic             en;
  logic             sig;
  logic             ack;
  logic [width-1:0] period;
  logic [width-1:0] high;
  logic             valid;
  logic             ovf;
  logic             it;

  modport master (output en, sig, ack, input period, high, valid, ovf, it);
  modport slave  (input en, sig, ack, output period, high, valid, ovf, it);
endinterface

// File: rtl/cnt_capture.sv
// Input-capture timer: measures period (rise to rise) and high time (rise to fall)
// of an asynchronous signal in clk cycles, with saturation flag and sticky interrupt.
module cnt_capture #(
  parameter int width = 32
) (
  input  logic          clk,
  input  logic          rst,
  cnt_capture_if.slave  bus
);
  localparam logic [width-1:0] CNT_MAX = '1;
  localparam logic [width-1:0] CNT_ONE = width'(1);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_RISE, RUN} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, s_q, s_dly_q;
  logic [width-1:0] pcnt_q, pcnt_d;
  logic             sat_q, sat_d;
  logic [width-1:0] hlat_q, hlat_d;
  logic [width-1:0] period_q, period_d;
  logic [width-1:0] high_q, high_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             it_q, it_d;
  logic             rise, fall;

  assign rise = s_q & ~s_dly_q;
  assign fall = ~s_q & s_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      s_dly_q  <= 1'b0;
      pcnt_q   <= '0;
      sat_q    <= 1'b0;
      hlat_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      it_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= bus.sig;
      s_q      <= sync1_q;
      s_dly_q  <= s_q;
      pcnt_q   <= pcnt_d;
      sat_q    <= sat_d;
      hlat_q   <= hlat_d;
      period_q <= period_d;
      high_q   <= high_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      it_q     <= it_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    sat_d    = sat_q;
    hlat_d   = hlat_q;
    period_d = period_q;
    high_d   = high_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      pcnt_d  = '0;
      sat_d   = 1'b0;
      hlat_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_LOW;
        // Both sync stages must show low: a freshly reset pipeline reads 0
        // even while sig is high, which would otherwise let a fake rise arm.
        WAIT_LOW: if (!sync1_q && !s_q) state_d = WAIT_RISE;
        WAIT_RISE: begin
          if (rise) begin
            state_d = RUN;
            pcnt_d  = CNT_ONE;
            sat_d   = 1'b0;
            hlat_d  = CNT_MAX;
          end
        end
        RUN: begin
          if (rise) begin
            period_d = pcnt_q;
            high_d   = hlat_q;
            ovf_d    = sat_q;
            valid_d  = 1'b1;
            pcnt_d   = CNT_ONE;
            sat_d    = 1'b0;
            hlat_d   = CNT_MAX;
          end else begin
            // pcnt holds at max, so a late fall latches max as well.
            if (pcnt_q == CNT_MAX) sat_d = 1'b1;
            else                   pcnt_d = pcnt_q + CNT_ONE;
            if (fall) hlat_d = pcnt_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    it_d = valid_d | (it_q & ~bus.ack);
  end

  assign bus.period = period_q;
  assign bus.high   = high_q;
  assign bus.valid  = valid_q;
  assign bus.ovf    = ovf_q;
  assign bus.it     = it_q;
endmodule

// File: tb/tb_cnt_capture.sv
// Directed bench for cnt_capture: table of waveform periods on an 8-bit instance,
// saturation on a 4-bit instance, plus interrupt, abort and reset sequences.
module tb_cnt_capture;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct { int h; int l; int ep; int eh; bit eo; } vec_t;
  typedef struct { logic [31:0] p; logic [31:0] h; logic o; } cap_t;

  cap_t q8[$];
  cap_t q4[$];
  vec_t tbl[8];

  cnt_capture_if #(.width(8)) b8();
  cnt_capture_if #(.width(4)) b4();

  cnt_capture #(.width(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  cnt_capture #(.width(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b8.valid) q8.push_back('{32'(b8.period), 32'(b8.high), b8.ovf});
    if (b4.valid) q4.push_back('{32'(b4.period), 32'(b4.high), b4.ovf});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_valid8(input int bound, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (b8.valid) ok = 1'b1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic gen8(input int h, input int l);
    b8.sig = 1'b1;
    repeat (h) @(negedge clk);
    b8.sig = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic gen4(input int h, input int l);
    b4.sig = 1'b1;
    repeat (h) @(negedge clk);
    b4.sig = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{4,   6,   10,  4,   1'b0};
    tbl[1] = '{4,   6,   10,  4,   1'b0};
    tbl[2] = '{2,   2,   4,   2,   1'b0};
    tbl[3] = '{5,   5,   10,  5,   1'b0};
    tbl[4] = '{2,   9,   11,  2,   1'b0};
    tbl[5] = '{100, 100, 200, 100, 1'b0};
    tbl[6] = '{200, 100, 255, 200, 1'b1};
    tbl[7] = '{3,   7,   10,  3,   1'b0};

    rst = 1'b1;
    b8.en = 1'b0; b8.sig = 1'b0; b8.ack = 1'b0;
    b4.en = 1'b0; b4.sig = 1'b0; b4.ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_period", 32'(b8.period), 0);
    chk("rst_high",   32'(b8.high),   0);
    chk("rst_valid",  32'(b8.valid),  0);
    chk("rst_ovf",    32'(b8.ovf),    0);
    chk("rst_it",     32'(b8.it),     0);

    // Saturation on the 4-bit instance (max 15)
    b4.en = 1'b1;
    repeat (4) @(negedge clk);
    q4.delete();
    gen4(3, 30);
    gen4(4, 6);
    gen4(4, 6);
    b4.sig = 1'b1;
    repeat (40) @(negedge clk);
    chk("sat_count", 32'(q4.size()), 3);
    if (q4.size() == 3) begin
      chk("sat0_period", q4[0].p, 15);
      chk("sat0_high",   q4[0].h, 3);
      chk("sat0_ovf",    32'(q4[0].o), 1);
      chk("sat1_period", q4[1].p, 10);
      chk("sat1_high",   q4[1].h, 4);
      chk("sat1_ovf",    32'(q4[1].o), 0);
      chk("sat2_period", q4[2].p, 10);
    end
    chk("sat_it", 32'(b4.it), 1);
    b4.en = 1'b0;

    // Table-driven periods on the 8-bit instance
    b8.en = 1'b1;
    repeat (4) @(negedge clk);
    q8.delete();
    for (int i = 0; i < 8; i++) gen8(tbl[i].h, tbl[i].l);
    gen8(4, 6);
    chk("tbl_count", 32'(q8.size()), 8);
    if (q8.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("vec%0d_period", i), q8[i].p, 32'(tbl[i].ep));
        chk($sformatf("vec%0d_high", i),   q8[i].h, 32'(tbl[i].eh));
        chk($sformatf("vec%0d_ovf", i),    32'(q8[i].o), 32'(tbl[i].eo));
      end
    end
    chk("tbl_it", 32'(b8.it), 1);

    // Interrupt handshake
    fork
      begin : wave
        repeat (4) gen8(4, 6);
      end
      begin : irq
        wait_valid8(20, "irq_valid1");
        repeat (2) @(negedge clk);
        b8.ack = 1'b1;
        @(negedge clk);
        b8.ack = 1'b0;
        chk("irq_ack_clr", 32'(b8.it), 0);
        @(negedge clk);
        b8.ack = 1'b1;
        @(negedge clk);
        chk("irq_ack_idle", 32'(b8.it), 0);
        wait_valid8(20, "irq_valid2");
        chk("irq_set_wins", 32'(b8.it), 1);
        chk("irq_period", 32'(b8.period), 10);
        b8.ack = 1'b0;
      end
    join

    // Enable abort mid-period
    b8.sig = 1'b1;
    repeat (4) @(negedge clk);
    b8.sig = 1'b0;
    repeat (2) @(negedge clk);
    q8.delete();
    b8.en = 1'b0;
    @(negedge clk);
    b8.en = 1'b1;
    repeat (4) @(negedge clk);
    gen8(5, 7);
    chk("abort_no_valid", 32'(q8.size()), 0);
    chk("abort_period_hold", 32'(b8.period), 10);
    chk("abort_high_hold",   32'(b8.high),   4);
    b8.sig = 1'b1;
    wait_valid8(10, "abort_valid");
    chk("abort_period", 32'(b8.period), 12);
    chk("abort_high",   32'(b8.high),   5);
    chk("abort_ovf",    32'(b8.ovf),    0);

    // Mid-operation reset with sig high and it set
    chk("mrst_it_before", 32'(b8.it), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_period", 32'(b8.period), 0);
    chk("mrst_high",   32'(b8.high),   0);
    chk("mrst_valid",  32'(b8.valid),  0);
    chk("mrst_ovf",    32'(b8.ovf),    0);
    chk("mrst_it",     32'(b8.it),     0);
    repeat (5) @(negedge clk);
    b8.sig = 1'b0;
    repeat (5) @(negedge clk);
    q8.delete();
    gen8(4, 6);
    chk("mrst_no_fake", 32'(q8.size()), 0);
    b8.sig = 1'b1;
    wait_valid8(10, "mrst_valid_after");
    chk("mrst_cap_period", 32'(b8.period), 10);
    chk("mrst_cap_high",   32'(b8.high),   4);
    chk("mrst_cap_it",     32'(b8.it),     1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
